// File: rtl/l2_cache_responder_pkg.sv
// Shared types and defaults for the L2 responder slice.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package l2_cache_responder_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  // Controller states: lookup/idle, victim eviction, line fill.
  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } lc3b_l2_state;

  localparam int L2_SETS     = 8;
  localparam int L2_OFF_BITS = 4;

  // Clears the byte-offset bits so an address names a whole line.
  function automatic lc3b_word line_align(input lc3b_word addr, input int off_bits);
    lc3b_word mask;
    mask = '1;
    mask = mask << off_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/l2_cache_responder_if.sv
// L2 request port plus physical-memory port of the L2 responder.
// Latency: n/a (wires only).
// Backpressure: requests and pmem operations are held until their resp pulse.
interface l2_cache_responder_if;
  import l2_cache_responder_pkg::*;

  lc3b_word       l2_address;
  logic           l2_read;
  logic           l2_write;
  lc3b_cache_line l2_wdata;
  lc3b_cache_line l2_rdata;
  logic           l2_mem_resp;

  lc3b_word       pmem_address;
  logic           pmem_read;
  logic           pmem_write;
  lc3b_cache_line pmem_wdata;
  lc3b_cache_line pmem_rdata;
  logic           pmem_resp;

  // Environment side: issues L2 requests and plays the memory.
  modport master (
    output l2_address, l2_read, l2_write, l2_wdata,
    input  l2_rdata, l2_mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  // Cache side.
  modport slave (
    input  l2_address, l2_read, l2_write, l2_wdata,
    output l2_rdata, l2_mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/l2_cache_responder_line_array.sv
// Direct-mapped line store: per-set valid, dirty, tag and 128-bit line.
// Latency: combinational read by index, writes land on the next rising edge.
// Backpressure: none; writes are accepted whenever their enable is high.
module l2_line_array
  import l2_cache_responder_pkg::*;
#(
  parameter int SETS     = L2_SETS,
  parameter int IDX_BITS = $clog2(L2_SETS),
  parameter int TAG_BITS = 16 - IDX_BITS - L2_OFF_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_BITS-1:0] rd_tag,
  output lc3b_cache_line      rd_line,
  input  logic                we_valid,
  input  logic                valid_in,
  input  logic                we_dirty,
  input  logic                dirty_in,
  input  logic                we_tag,
  input  logic [TAG_BITS-1:0] tag_in,
  input  logic                we_line,
  input  lc3b_cache_line      line_in
);

  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;
  logic [TAG_BITS-1:0] tag_q [SETS];
  lc3b_cache_line      line_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = line_q[idx];

  // Status bits: the only storage cleared by reset, so every line starts invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (we_valid) valid_q[idx] <= valid_in;
      if (we_dirty) dirty_q[idx] <= dirty_in;
    end
  end

  // Tag and data payload; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (we_tag)  tag_q[idx]  <= tag_in;
    if (we_line) line_q[idx] <= line_in;
  end

endmodule

// File: rtl/l2_cache_responder.sv
// Direct-mapped write-back L2: answers line reads/writes, fills and evicts via pmem.
// Latency: hit 0 extra cycles; clean read miss fill+1; dirty miss writeback(+fill)+1.
// Backpressure: requester holds read/write until l2_mem_resp; pmem ops held until pmem_resp.
module l2_cache_responder
  import l2_cache_responder_pkg::*;
#(
  parameter int SETS     = L2_SETS,
  parameter int OFF_BITS = L2_OFF_BITS
) (
  input logic           clk,
  input logic           reset,
  l2_cache_responder_if.slave bus
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 16 - IDX_BITS - OFF_BITS;

  lc3b_l2_state state_q, state_d;

  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] req_tag;
  logic                unused_addr_bits;

  logic                rd_valid, rd_dirty;
  logic [TAG_BITS-1:0] rd_tag;
  lc3b_cache_line      rd_line;

  logic                we_valid, valid_in, we_dirty, dirty_in, we_tag, we_line;
  lc3b_cache_line      line_in;

  logic                hit, victim_dirty;
  logic                resp;
  lc3b_cache_line      rdata;
  logic                pmem_rd, pmem_wr;
  lc3b_word            pmem_addr;
  lc3b_cache_line      pmem_wd;

  assign idx              = bus.l2_address[IDX_BITS+OFF_BITS-1:OFF_BITS];
  assign req_tag          = bus.l2_address[15:IDX_BITS+OFF_BITS];
  assign unused_addr_bits = ^bus.l2_address[OFF_BITS-1:0];

  l2_line_array #(
    .SETS     (SETS),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .idx      (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we_valid (we_valid),
    .valid_in (valid_in),
    .we_dirty (we_dirty),
    .dirty_in (dirty_in),
    .we_tag   (we_tag),
    .tag_in   (req_tag),
    .we_line  (we_line),
    .line_in  (line_in)
  );

  assign hit          = rd_valid && (rd_tag == req_tag);
  assign victim_dirty = rd_valid && rd_dirty;

  // State register; reset abandons any in-flight miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CHECK;
    else       state_q <= state_d;
  end

  // Next state, array write enables and all outputs. Everything is forced low
  // while reset is high so pmem ops drop immediately and nothing is installed.
  always_comb begin
    state_d   = state_q;
    resp      = 1'b0;
    rdata     = '0;
    pmem_rd   = 1'b0;
    pmem_wr   = 1'b0;
    pmem_addr = '0;
    pmem_wd   = '0;
    we_valid  = 1'b0;
    valid_in  = 1'b0;
    we_dirty  = 1'b0;
    dirty_in  = 1'b0;
    we_tag    = 1'b0;
    we_line   = 1'b0;
    line_in   = bus.l2_wdata;

    if (!reset) begin
      unique case (state_q)
        CHECK: begin
          // Write wins if both strobes are (illegally) high.
          if (bus.l2_write) begin
            if (hit || !victim_dirty) begin
              resp     = 1'b1;
              we_line  = 1'b1;
              we_tag   = 1'b1;
              we_valid = 1'b1;
              valid_in = 1'b1;
              we_dirty = 1'b1;
              dirty_in = 1'b1;
            end else begin
              state_d = WRITEBACK;
            end
          end else if (bus.l2_read) begin
            if (hit) begin
              resp  = 1'b1;
              rdata = rd_line;
            end else if (victim_dirty) begin
              state_d = WRITEBACK;
            end else begin
              state_d = FILL;
            end
          end
        end

        WRITEBACK: begin
          pmem_wr   = 1'b1;
          pmem_addr = {rd_tag, idx, {OFF_BITS{1'b0}}};
          pmem_wd   = rd_line;
          if (bus.pmem_resp) begin
            we_dirty = 1'b1;
            dirty_in = 1'b0;
            // A write finishes in CHECK, where the now-clean victim is overwritten.
            state_d  = bus.l2_write ? CHECK : FILL;
          end
        end

        FILL: begin
          pmem_rd   = 1'b1;
          pmem_addr = {req_tag, idx, {OFF_BITS{1'b0}}};
          if (bus.pmem_resp) begin
            line_in  = bus.pmem_rdata;
            we_line  = 1'b1;
            we_tag   = 1'b1;
            we_valid = 1'b1;
            valid_in = 1'b1;
            we_dirty = 1'b1;
            dirty_in = 1'b0;
            state_d  = CHECK;
          end
        end

        default: state_d = CHECK;
      endcase
    end
  end

  assign bus.l2_mem_resp  = resp;
  assign bus.l2_rdata     = rdata;
  assign bus.pmem_read    = pmem_rd;
  assign bus.pmem_write   = pmem_wr;
  assign bus.pmem_address = pmem_addr;
  assign bus.pmem_wdata   = pmem_wd;

endmodule
